// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: FSM states,
// frame geometry and the state decode used for the stream-ready flag.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // States in which a byte of the load frame may be consumed.
  function automatic logic rx_state(state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CKSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready are both 1.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes into a little-endian 32-bit word; word_valid
// and word are combinational so the caller can register the write on the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  lane
);

  logic [1:0]  lane_q;
  logic [31:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
    end else if (clr) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
    end else if (byte_valid) begin
      asm_q[{lane_q, 3'b000} +: 8] <= byte_data;
      lane_q                       <= lane_q + 2'd1;
    end
  end

  // The top lane is taken straight from the bus so the full word exists on the 4th-byte edge.
  always_comb begin
    word        = asm_q;
    word[31:24] = byte_data;
  end

  assign word_valid = byte_valid && (lane_q == 2'd3) && !clr;
  assign lane       = lane_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN_LO, LEN_HI, 4*N payload bytes and a checksum byte, writes
// words to instruction memory and holds the core in reset until the image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         done,
  output logic         error,
  output state_t       state_dbg
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t                state, next_state;
  logic [7:0]            len_lo;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            cksum;

  logic                  xfer, data_xfer, load_start, last_byte, len_too_big;
  logic [15:0]           len_full;
  logic                  pk_word_valid;
  logic [31:0]           pk_word;
  logic [1:0]            pk_lane;

  assign xfer        = bus.in_valid && bus.in_ready;
  assign data_xfer   = xfer && (state == ST_DATA);
  assign load_start  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign len_full    = {bus.in_data, len_lo};
  assign len_too_big = {1'b0, len_full} > CAPACITY;
  assign last_byte   = data_xfer && (pk_lane == 2'd3) && (words_left == 16'd1);
  assign state_dbg   = state;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_start),
    .byte_valid (data_xfer),
    .byte_data  (bus.in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .lane       (pk_lane)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_LEN_LO;
      ST_LEN_LO: if (xfer)  next_state = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0) next_state = ST_CKSUM;
          else if (len_too_big)  next_state = ST_ERROR;
          else                   next_state = ST_DATA;
        end
      end
      ST_DATA:   if (last_byte) next_state = ST_CKSUM;
      ST_CKSUM:  if (xfer) next_state = (bus.in_data == cksum) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:  if (start) next_state = ST_LEN_LO;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Status flags and in_ready are registered from next_state so they change on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rst       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      len_lo         <= 8'd0;
      words_left     <= 16'd0;
      word_idx       <= '0;
      cksum          <= 8'd0;
    end else begin
      bus.in_ready <= rx_state(next_state);
      core_rst     <= (next_state != ST_DONE);
      done         <= (next_state == ST_DONE);
      error        <= (next_state == ST_ERROR);
      bus.imem_we  <= pk_word_valid;

      if (pk_word_valid) begin
        bus.imem_wdata <= DATA_WIDTH'(pk_word);
        bus.imem_addr  <= word_idx;
        word_idx       <= word_idx + 1'b1;
        words_left     <= words_left - 16'd1;
      end
      if (xfer && (state == ST_LEN_LO)) len_lo <= bus.in_data;
      if (xfer && (state == ST_LEN_HI)) words_left <= len_full;
      if (data_xfer) cksum <= cksum + bus.in_data;
      if (load_start) begin
        word_idx   <= '0;
        words_left <= 16'd0;
        cksum      <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: frames are built by a byte-level
// model, expected writes queued up front and compared as the DUT emits them.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W  = AW + DW;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   core_rst, done, error;
  state_t state_dbg;

  imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   pl[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.imem_we === 1'b1) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", 64'({bus.imem_addr, bus.imem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic we_exp, input string tag);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_timeout"}, 64'(guard < 16), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check({tag, "_we"}, 64'(bus.imem_we), 64'(we_exp));
  endtask

  task automatic idle_gap(input int n, input bit allow_start);
    for (int i = 0; i < n; i++) begin
      start = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("gap_we", 64'(bus.imem_we), 64'd0);
    end
  endtask

  // Model: word w = sum of payload byte (4w+k) * 256**k; checksum = payload sum mod 256.
  task automatic queue_words(input int n_words);
    for (int w = 0; w < n_words; w++) begin
      logic [31:0] word;
      word = 32'd0;
      for (int k = 0; k < 4; k++) word += 32'(pl[4*w+k]) << (8*k);
      exp_q.push_back({AW'(w), word});
    end
  endtask

  task automatic run_image(input int n, input bit bad_cksum, input bit gaps, input bit starts);
    int          sum;
    logic [7:0]  ck;
    bit          too_big;
    sum = 0;
    foreach (pl[i]) sum += int'(pl[i]);
    ck      = 8'(sum % 256) + (bad_cksum ? 8'd1 : 8'd0);
    too_big = n > (1 << AW);
    if (!too_big) queue_words(n);

    pulse_start();
    check("start_done", 64'(done), 64'd0);
    check("start_error", 64'(error), 64'd0);
    check("start_core_rst", 64'(core_rst), 64'd1);
    check("start_ready", 64'(bus.in_ready), 64'd1);

    send_byte(8'(n), 1'b0, "len_lo");
    send_byte(8'(n >> 8), 1'b0, "len_hi");
    if (too_big) begin
      check("ovf_error", 64'(error), 64'd1);
      check("ovf_done", 64'(done), 64'd0);
      check("ovf_core_rst", 64'(core_rst), 64'd1);
      check("ovf_ready", 64'(bus.in_ready), 64'd0);
      return;
    end
    for (int i = 0; i < 4*n; i++) begin
      send_byte(pl[i], (i % 4) == 3, "data");
      if (gaps) idle_gap($urandom_range(0, 2), starts);
    end
    send_byte(ck, 1'b0, "cksum");
    check("end_done", 64'(done), 64'(!bad_cksum));
    check("end_error", 64'(error), 64'(bad_cksum));
    check("end_core_rst", 64'(core_rst), 64'(bad_cksum));
    check("end_ready", 64'(bus.in_ready), 64'd0);
    check("end_state", 64'(state_dbg), 64'(bad_cksum ? ST_ERROR : ST_DONE));
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_random(input int nbytes);
    pl.delete();
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of DATA: one word written, second word half assembled.
    fill_random(16);
    queue_words(1);
    pulse_start();
    send_byte(8'd4, 1'b0, "mid_len_lo");
    send_byte(8'd0, 1'b0, "mid_len_hi");
    for (int i = 0; i < 6; i++) send_byte(pl[i], i == 3, "mid_data");
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_we", 64'(bus.imem_we), 64'd0);
    check("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
    check("mid_rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("mid_rst_core_rst", 64'(core_rst), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(16);
    run_image(4, 1'b0, 1'b0, 1'b0);

    // Known two-instruction image, good then bad checksum.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_image(2, 1'b0, 1'b0, 1'b0);
    run_image(2, 1'b1, 1'b0, 1'b0);

    // Empty image and one word over capacity.
    pl.delete();
    run_image(0, 1'b0, 1'b0, 1'b0);
    run_image(1025, 1'b0, 1'b0, 1'b0);

    // Gapped stream with stray start pulses, and checksum wraparound.
    fill_random(20);
    run_image(5, 1'b0, 1'b1, 1'b1);
    pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_image(1, 1'b0, 1'b1, 1'b1);

    // Restart from DONE: second image overwrites from address 0.
    fill_random(12);
    run_image(3, 1'b0, 1'b1, 1'b0);
    fill_random(8);
    run_image(2, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
